// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: request/response and SPI pin bundle for spi_master_ctrl.
// The master modport is the controller's view; the slave modport is the view
// of whatever sits on the other side (the requester and the SPI target).
interface spi_master_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
);
    logic [1:0]        mode;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic              miso;

    modport master (
        input  mode, clk_div, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, cs, sclk, mosi
    );

    modport slave (
        output mode, clk_div, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, cs, sclk, mosi
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-word SPI master for modes 0..3.
// Frame: ASSERT (H cycles, cs low, first bit on mosi), XFER (2*DATA_W sclk
// toggles, one every H cycles), HOLD (H cycles), GAP (H cycles, cs high).
// H = clk_div + 1. Optional build macro SPI_MASTER_LSB_FIRST_EN switches
// both directions to LSB-first; default is MSB-first with identical timing.
module spi_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_master_ctrl_if.master  bus
);
    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [EW-1:0]     edge_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              cs_q;
    logic              sclk_q;
    logic              rx_valid_q;
    logic              busy_q;

    logic [DATA_W-1:0] tx_shift_d;
    logic [DATA_W-1:0] rx_shift_d;
    logic [EW-1:0]     edge_d;
    logic              half_done;
    logic              sample_edge;
    logic              shift_edge;

    // edge_d is the number of the toggle about to happen (1..2*DATA_W)
    assign edge_d    = edge_q + 1'b1;
    assign half_done = (cnt_q == div_q);

    // Odd toggles are leading edges; CPHA=0 samples on leading, CPHA=1 on
    // trailing. Every other toggle shifts mosi, except toggle 1 (mosi already
    // carries the first bit) and the final toggle (nothing left to send).
    assign sample_edge = edge_d[0] ^ mode_q[0];
    assign shift_edge  = !sample_edge && (edge_d != EW'(1)) && (edge_d != EW'(EDGES));

    // Bit-order dependent shift paths; mosi is always taken from the outgoing end.
    always_comb begin
`ifdef SPI_MASTER_LSB_FIRST_EN
        tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
        rx_shift_d = {bus.miso, rx_shift_q[DATA_W-1:1]};
`else
        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
`endif
    end

    // Frame sequencer with registered pin and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            div_q      <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Idle clock level follows the live CPOL so the line is
                    // already correct when cs drops.
                    sclk_q <= bus.mode[1];
                    if (bus.tx_valid) begin
                        mode_q     <= bus.mode;
                        div_q      <= bus.clk_div;
                        tx_shift_q <= bus.tx_data;
                        rx_shift_q <= '0;
                        cnt_q      <= '0;
                        edge_q     <= '0;
                        cs_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ASSERT;
                    end
                end
                ASSERT, XFER: begin
                    if (half_done) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_d;
                        if (sample_edge) begin
                            rx_shift_q <= rx_shift_d;
                        end
                        if (shift_edge) begin
                            tx_shift_q <= tx_shift_d;
                        end
                        state_q <= (edge_d == EW'(EDGES)) ? HOLD : XFER;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        cnt_q      <= '0;
                        cs_q       <= 1'b1;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shift_q;
                        state_q    <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    sclk_q <= mode_q[1];
                    if (half_done) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign bus.mosi = tx_shift_q[0];
`else
    assign bus.mosi = tx_shift_q[DATA_W-1];
`endif
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.cs       = cs_q;
    assign bus.sclk     = sclk_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed frames for spi_master_ctrl with hand-computed
// timing and data expectations. Cycle 1 is the first cycle after the
// handshake edge; edge k is expected first visible at cycle 1 + k*H.
module tb_spi_master_ctrl;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

    spi_master_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Order in which a word's bits appear on the wire, packed MSB-first.
    function automatic logic [7:0] ser(input logic [7:0] w);
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) ser[i] = w[7-i];
`else
        ser = w;
`endif
    endfunction

    // miso sources: loopback, constant, or a slave model shifting on leading edges
    logic       loop_en    = 1'b0;
    logic       model_en   = 1'b0;
    logic       tie_val    = 1'b0;
    logic       model_bit  = 1'b0;
    logic       model_cpol = 1'b0;
    logic [7:0] model_word = 8'h00;
    int         model_idx  = 7;
    logic       model_prev = 1'b0;

    assign bus.miso = loop_en ? bus.mosi : (model_en ? model_bit : tie_val);

    always @(negedge clk) begin
        if (bus.cs) begin
            model_idx  = 7;
            model_prev = bus.sclk;
        end else begin
            if (bus.sclk != model_prev && bus.sclk != model_cpol && model_idx >= 0) begin
                model_bit = model_word[model_idx];
                model_idx--;
            end
            model_prev = bus.sclk;
        end
    end

    // Per-frame observations
    int         cs_low_cnt, cs_first, cs_high_after, toggles, rises;
    int         first_edge, last_edge, rxv_cnt, rxv_cyc, rdy_cyc, unstable;
    logic [7:0] mosi_word, got_rx;

    task automatic launch(input logic [1:0] m, input logic [7:0] d, input logic [7:0] data);
        @(negedge clk);
        bus.mode     = m;
        bus.clk_div  = d;
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // Observe from cycle 1 until tx_ready returns (or max_cyc expires).
    task automatic watch_frame(input logic [1:0] m, input int max_cyc);
        logic prev_sclk, prev_mosi, lead;
        cs_low_cnt = 0; cs_first = 0; cs_high_after = 0; toggles = 0; rises = 0;
        first_edge = 0; last_edge = 0; rxv_cnt = 0; rxv_cyc = 0; rdy_cyc = 0;
        unstable = 0; mosi_word = 8'h00; got_rx = 8'h00;
        prev_sclk = m[1];
        prev_mosi = bus.mosi;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (!bus.cs) begin
                cs_low_cnt++;
                if (cs_first == 0) cs_first = c;
            end else if (cs_low_cnt > 0) begin
                cs_high_after++;
            end
            if (bus.sclk != prev_sclk) begin
                toggles++;
                if (bus.sclk) rises++;
                if (first_edge == 0) first_edge = c;
                last_edge = c;
                lead = (bus.sclk != m[1]);
                if (lead != m[0]) mosi_word = {mosi_word[6:0], bus.mosi};
                if (!lead && bus.mosi != prev_mosi) unstable++;
            end
            if (bus.rx_valid) begin
                rxv_cnt++;
                rxv_cyc = c;
                got_rx  = bus.rx_data;
            end
            prev_sclk = bus.sclk;
            prev_mosi = bus.mosi;
            if (bus.tx_ready) begin
                rdy_cyc = c;
                $display("frame mode=%0d rx=0x%0h mosi=0x%0h cs_low=%0d edges=%0d rdy=%0d",
                         m, got_rx, mosi_word, cs_low_cnt, toggles, rdy_cyc);
                return;
            end
        end
        $display("frame mode=%0d did not return to idle within %0d cycles", m, max_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg;
        logic ps;
        int rxv_seen;

        bus.mode     = 2'd0;
        bus.clk_div  = '0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs",       bus.cs,       1);
        check("rst_sclk",     bus.sclk,     0);
        check("rst_mosi",     bus.mosi,     0);
        check("rst_rx_data",  bus.rx_data,  0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_busy",     bus.busy,     0);
        check("rst_tx_ready", bus.tx_ready, 1);
        reset_n = 1'b1;

        // Mode 0, H=1, loopback 0xA5
        loop_en = 1'b1;
        launch(2'd0, 8'd0, 8'hA5);
        watch_frame(2'd0, 200);
        check("m0_cs_low",   cs_low_cnt, 17);
        check("m0_rises",    rises,      8);
        check("m0_toggles",  toggles,    16);
        check("m0_edge1",    first_edge, 2);
        check("m0_edge16",   last_edge,  17);
        check("m0_rxv_cnt",  rxv_cnt,    1);
        check("m0_rxv_cyc",  rxv_cyc,    18);
        check("m0_rdy_cyc",  rdy_cyc,    19);
        check("m0_rx",       got_rx,     8'hA5);
        check("m0_mosi",     mosi_word,  ser(8'hA5));

        // Mode 3, H=4, miso tied high, 0x3C
        loop_en = 1'b0;
        tie_val = 1'b1;
        @(negedge clk);
        bus.mode = 2'd3;
        repeat (2) @(negedge clk);
        check("m3_idle_sclk", bus.sclk, 1);
        launch(2'd3, 8'd3, 8'h3C);
        watch_frame(2'd3, 400);
        check("m3_toggles",  toggles,    16);
        check("m3_edge1",    first_edge, 5);
        check("m3_edge16",   last_edge,  65);
        check("m3_cs_low",   cs_low_cnt, 68);
        check("m3_rxv_cyc",  rxv_cyc,    69);
        check("m3_rdy_cyc",  rdy_cyc,    73);
        check("m3_rx",       got_rx,     8'hFF);
        check("m3_mosi",     mosi_word,  ser(8'h3C));
        check("m3_end_sclk", bus.sclk,   1);

        // Mode 1, H=2, slave model sends 0x96
        tie_val    = 1'b0;
        model_en   = 1'b1;
        model_cpol = 1'b0;
        model_word = ser(8'h96);
        launch(2'd1, 8'd1, 8'hC3);
        watch_frame(2'd1, 300);
        check("m1_rx",       got_rx,     8'h96);
        check("m1_mosi",     mosi_word,  ser(8'hC3));
        check("m1_unstable", unstable,   0);
        check("m1_rxv_cyc",  rxv_cyc,    35);
        check("m1_rdy_cyc",  rdy_cyc,    37);
        model_en = 1'b0;

        // Back-to-back with tx_valid held; tx_data change while busy is ignored
        loop_en = 1'b1;
        @(negedge clk);
        bus.mode     = 2'd0;
        bus.clk_div  = 8'd0;
        bus.tx_data  = 8'h11;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_data = 8'h22;
        watch_frame(2'd0, 100);
        check("b2b_rx1",      got_rx,        8'h11);
        check("b2b_rdy1",     rdy_cyc,       19);
        check("b2b_cs_high",  cs_high_after, 2);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        watch_frame(2'd0, 100);
        check("b2b_cs_first", cs_first,   1);
        check("b2b_rx2",      got_rx,     8'h22);
        check("b2b_cs_low2",  cs_low_cnt, 17);

        // Reset mid-frame after the 3rd edge
        launch(2'd0, 8'd1, 8'hF0);
        tg = 0;
        ps = bus.sclk;
        for (int c = 0; c < 100 && tg < 3; c++) begin
            @(negedge clk);
            if (bus.sclk != ps) tg++;
            ps = bus.sclk;
        end
        check("abort_edges", tg, 3);
        reset_n = 1'b0;
        #1;
        check("abort_cs",       bus.cs,       1);
        check("abort_sclk",     bus.sclk,     0);
        check("abort_busy",     bus.busy,     0);
        check("abort_tx_ready", bus.tx_ready, 1);
        check("abort_rx_data",  bus.rx_data,  0);
        rxv_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 3) reset_n = 1'b1;
            if (bus.rx_valid) rxv_seen++;
        end
        check("abort_no_rxv", rxv_seen, 0);
        launch(2'd0, 8'd0, 8'h5A);
        watch_frame(2'd0, 100);
        check("after_rx",      got_rx,     8'h5A);
        check("after_rxv_cnt", rxv_cnt,    1);
        check("after_cs_low",  cs_low_cnt, 17);

`ifdef SPI_MASTER_LSB_FIRST_EN
        // LSB-first: 0x01 puts its single 1 on the first bit time
        launch(2'd0, 8'd0, 8'h01);
        watch_frame(2'd0, 100);
        check("lsb_mosi", mosi_word, 8'h80);
        check("lsb_rx",   got_rx,    8'h01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
